// File: rtl/pe_pkg.sv
// Shared PE datapath constants, psum stage state encoding and
// sign-magnitude <-> two's-complement helpers.
package pe_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned FRAC_W    = 12;
  localparam int unsigned PROD_W    = 32;
  localparam int unsigned PROD_FRAC = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    PSUM = 2'd2,
    OUT  = 2'd3
  } psum_state_t;

  // Negative zero (0x8000) maps to 0.
  function automatic logic signed [DATA_W-1:0] sm2tc(input logic [DATA_W-1:0] sm);
    logic signed [DATA_W-1:0] mag;
    mag = {1'b0, sm[DATA_W-2:0]};
    return sm[DATA_W-1] ? -mag : mag;
  endfunction

  // Input is expected in [-32767, 32767]; zero always encodes as 0x0000.
  function automatic logic [DATA_W-1:0] tc2sm(input logic signed [DATA_W-1:0] v);
    logic signed [DATA_W-1:0] neg;
    neg = -v;
    return v[DATA_W-1] ? {1'b1, neg[DATA_W-2:0]} : {1'b0, v[DATA_W-2:0]};
  endfunction

endpackage

// File: rtl/pe_psum_accum_if.sv
// Product / incoming-psum / result handshakes of the psum accumulation stage.
interface pe_psum_accum_if
  import pe_pkg::*;
#(
  parameter int unsigned LEN_W = 8
);

  logic [LEN_W-1:0]  cfg_len;
  logic              prod_valid;
  logic              prod_ready;
  logic [PROD_W-1:0] prod_data;
  logic              psum_in_valid;
  logic              psum_in_ready;
  logic [DATA_W-1:0] psum_in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              sat_flag;
  logic              busy;

  modport master (
    output cfg_len, prod_valid, prod_data, psum_in_valid, psum_in_data, out_ready,
    input  prod_ready, psum_in_ready, out_valid, out_data, sat_flag, busy
  );

  modport slave (
    input  cfg_len, prod_valid, prod_data, psum_in_valid, psum_in_data, out_ready,
    output prod_ready, psum_in_ready, out_valid, out_data, sat_flag, busy
  );

endinterface

// File: rtl/psum_round_sat.sv
// Round-half-up Q.24 accumulator to Q.12, saturate to +/-0x7FFF, encode sign-magnitude.
module psum_round_sat
  import pe_pkg::*;
#(
  parameter int unsigned ACC_W = 40
) (
  input  logic signed [ACC_W-1:0] i_acc,
  output logic [DATA_W-1:0]       o_data,
  output logic                    o_sat
);

  localparam logic signed [ACC_W:0] MaxVal = 32767;
  localparam logic signed [ACC_W:0] MinVal = -32767;
  localparam logic signed [ACC_W:0] Half   = 2048;

  logic signed [ACC_W:0] w_sum;
  logic signed [ACC_W:0] w_r;

  always_comb begin
    // One guard bit so the rounding add cannot wrap.
    w_sum = {i_acc[ACC_W-1], i_acc} + Half;
    w_r   = w_sum >>> FRAC_W;
    if (w_r > MaxVal) begin
      o_data = 16'h7FFF;
      o_sat  = 1'b1;
    end else if (w_r < MinVal) begin
      o_data = 16'hFFFF;
      o_sat  = 1'b1;
    end else begin
      o_data = tc2sm(w_r[DATA_W-1:0]);
      o_sat  = 1'b0;
    end
  end

endmodule

// File: rtl/pe_psum_accum.sv
// Partial-sum accumulation stage: sums cfg_len Q7.24 products, optionally adds a
// neighbour psum, then emits a rounded, saturated sign-magnitude Q3.12 result.
module pe_psum_accum
  import pe_pkg::*;
#(
  parameter int unsigned ACC_W       = 40,
  parameter int unsigned LEN_W       = 8,
  parameter bit          USE_PSUM_IN = 1'b1
) (
  input logic            clk,
  input logic            rst_n,
  pe_psum_accum_if.slave bus
);

  psum_state_t             r_state, w_state_d, w_done_st;
  logic signed [ACC_W-1:0] r_acc, w_acc_d;
  logic [LEN_W-1:0]        r_cnt, w_cnt_d;
  logic [LEN_W-1:0]        r_len, w_len_d;
  logic [DATA_W-1:0]       r_out_data, w_rs_data;
  logic                    r_sat, w_rs_sat;
  logic                    w_load_out;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] w_psum_ext;
  logic signed [DATA_W-1:0] w_psum_tc;

  assign w_prod_ext = {{(ACC_W-PROD_W){bus.prod_data[PROD_W-1]}}, bus.prod_data};
  assign w_psum_tc  = sm2tc(bus.psum_in_data);
  assign w_psum_ext = {{(ACC_W-DATA_W){w_psum_tc[DATA_W-1]}}, w_psum_tc} <<< FRAC_W;
  assign w_done_st  = USE_PSUM_IN ? PSUM : OUT;

  always_comb begin
    w_state_d = r_state;
    w_acc_d   = r_acc;
    w_cnt_d   = r_cnt;
    w_len_d   = r_len;
    unique case (r_state)
      IDLE: begin
        if (bus.prod_valid) begin
          w_acc_d   = w_prod_ext;
          w_cnt_d   = LEN_W'(1);
          w_len_d   = (bus.cfg_len == '0) ? LEN_W'(1) : bus.cfg_len;
          w_state_d = (w_len_d > LEN_W'(1)) ? ACC : w_done_st;
        end
      end
      ACC: begin
        if (bus.prod_valid) begin
          w_acc_d = r_acc + w_prod_ext;
          w_cnt_d = r_cnt + LEN_W'(1);
          if (w_cnt_d == r_len) w_state_d = w_done_st;
        end
      end
      PSUM: begin
        if (bus.psum_in_valid) begin
          w_acc_d   = r_acc + w_psum_ext;
          w_state_d = OUT;
        end
      end
      OUT: begin
        if (bus.out_ready) w_state_d = IDLE;
      end
      default: w_state_d = IDLE;
    endcase
  end

  // Result register captures the final sum on the edge that enters OUT.
  assign w_load_out = (w_state_d == OUT) && (r_state != OUT);

  psum_round_sat #(
    .ACC_W(ACC_W)
  ) u_round_sat (
    .i_acc (w_acc_d),
    .o_data(w_rs_data),
    .o_sat (w_rs_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_len      <= '0;
      r_out_data <= '0;
      r_sat      <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_acc   <= w_acc_d;
      r_cnt   <= w_cnt_d;
      r_len   <= w_len_d;
      if (w_load_out) begin
        r_out_data <= w_rs_data;
        r_sat      <= w_rs_sat;
      end
    end
  end

  assign bus.prod_ready    = (r_state == IDLE) || (r_state == ACC);
  assign bus.psum_in_ready = USE_PSUM_IN && (r_state == PSUM);
  assign bus.out_valid     = (r_state == OUT);
  assign bus.out_data      = r_out_data;
  assign bus.sat_flag      = r_sat;
  assign bus.busy          = (r_state != IDLE);

endmodule
